// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode/hazard definitions: FSM state encoding, bubble instruction, register-specifier width.
package id_hazard_ctrl_pkg;

  localparam int REG_BITS_DEF = 3;

  // Instruction word the ID/EX register loads when a bubble is injected.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/id_hazard_ctrl_track.sv
// One in-flight destination tracking slot {v, rd, load}; loads on en, otherwise holds.
// Latency: one cycle from nxt_* to outputs; no backpressure of its own (en is the pipe enable).
module hz_track_entry
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                nxt_v,
  input  logic [REG_BITS-1:0] nxt_rd,
  input  logic                nxt_load,
  output logic                v,
  output logic [REG_BITS-1:0] rd,
  output logic                load
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v    <= 1'b0;
      rd   <= '0;
      load <= 1'b0;
    end else if (en) begin
      v    <= nxt_v;
      rd   <= nxt_rd;
      load <= nxt_load;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage RAW hazard, mem-wait freeze and HALT drain control for the ID/EX boundary.
// Latency: hazard -> stall/ifid_en same cycle; tracking/state on next edge. mem_wait freezes everything.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS     = REG_BITS_DEF,
  parameter int FORWARD_EX   = 0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic                id_rs_valid,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rt_valid,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_wr_valid,
  input  logic                id_is_load,
  input  logic                id_halt,
  input  logic                mem_wait,
  output logic                stall,
  output logic                ifid_en,
  output logic                pipe_en,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t        state;
  logic [DW-1:0] drain_cnt;

  logic                ex_v, ex_load, mem_v, mem_load;
  logic [REG_BITS-1:0] ex_rd, mem_rd;
  logic                rs_ex, rt_ex, rs_mem, rt_mem;
  logic                hz_all, hz_lu, hz;
  logic                unused_mem_load;

  // A stalled decode must not enter EX, so the EX slot takes a bubble.
  hz_track_entry #(.REG_BITS(REG_BITS)) u_ex (
    .clk      (clk),
    .rst      (rst),
    .en       (pipe_en),
    .nxt_v    (stall ? 1'b0 : id_wr_valid),
    .nxt_rd   (stall ? '0 : id_rd),
    .nxt_load (stall ? 1'b0 : id_is_load),
    .v        (ex_v),
    .rd       (ex_rd),
    .load     (ex_load)
  );

  hz_track_entry #(.REG_BITS(REG_BITS)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .en       (pipe_en),
    .nxt_v    (ex_v),
    .nxt_rd   (ex_rd),
    .nxt_load (ex_load),
    .v        (mem_v),
    .rd       (mem_rd),
    .load     (mem_load)
  );

  // MEM's load bit is carried for debug visibility only; no hazard depends on it.
  assign unused_mem_load = mem_load;

  assign rs_ex  = id_rs_valid && ex_v  && (id_rs == ex_rd);
  assign rt_ex  = id_rt_valid && ex_v  && (id_rt == ex_rd);
  assign rs_mem = id_rs_valid && mem_v && (id_rs == mem_rd);
  assign rt_mem = id_rt_valid && mem_v && (id_rt == mem_rd);

  // WB is never checked: the register file writes in the first half-cycle.
  assign hz_all = rs_ex || rt_ex || rs_mem || rt_mem;
  assign hz_lu  = (rs_ex || rt_ex) && ex_load;
  assign hz     = (FORWARD_EX != 0) ? hz_lu : hz_all;

  always_comb begin
    pipe_en = !mem_wait && (state != ST_HALTED);
    stall   = 1'b0;
    ifid_en = 1'b0;
    case (state)
      ST_RUN: begin
        stall   = pipe_en && hz;
        ifid_en = pipe_en && !hz;
      end
      ST_DRAIN: begin
        stall   = pipe_en;
        ifid_en = 1'b0;
      end
      default: begin
        stall   = 1'b0;
        ifid_en = 1'b0;
      end
    endcase
  end

  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (pipe_en && !hz && id_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (pipe_en) begin
            drain_cnt <= drain_cnt - DW'(1);
            if (drain_cnt == DW'(1)) state <= ST_HALTED;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Pipeline control block sitting directly upstream of the ID/EX register.
- Tracks destination registers of instructions in flight in EX and MEM and detects RAW hazards against the instruction in decode.
- Drives the ID/EX bubble-insert (stall) and the register enables (en) for IF/ID, ID/EX and the later pipeline registers.
- Also freezes the pipe on a data-memory wait, drains the pipe on HALT, and keeps a saturating stall-cycle counter.

Parameters:
- REG_BITS, 3, width of register specifiers (8 GPRs).
- FORWARD_EX, 0, 0: stall on any match in EX or MEM; 1: stall only on a load-use match in EX.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT issues before halted asserts.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_rs  in  REG_BITS  decode source 1
- id_rs_valid  in  1  decode reads rs
- id_rt  in  REG_BITS  decode source 2
- id_rt_valid  in  1  decode reads rt
- id_rd  in  REG_BITS  decode destination
- id_wr_valid  in  1  decode writes rd
- id_is_load  in  1  decode instruction is a load
- id_halt  in  1  decode instruction is HALT
- mem_wait  in  1  data memory not ready; freeze the pipe
- stall  out  1  to ID/EX: inject bubble (instr 16'h0800, controls zeroed)
- ifid_en  out  1  PC and IF/ID write enable
- pipe_en  out  1  ID/EX, EX/MEM, MEM/WB write enable
- halted  out  1  pipe drained after HALT
- stall_cycles  out  CNT_W  count of cycles with stall=1

Behaviour:
- Reset (rst=0, async): ex/mem tracking entries invalid, state RUN, drain counter 0, stall_cycles 0.
- Reset output values: stall=0, ifid_en=1, pipe_en=1, halted=0.
- Tracking shift register: entries {v, rd, load} for EX and MEM, updated only when pipe_en=1.
  - MEM <= EX.
  - EX <= bubble (v=0) if stall=1; otherwise {id_wr_valid, id_rd, id_is_load}.
  - With pipe_en=0, both entries hold.
- Hazard (combinational on current inputs and entries):
  - With FORWARD_EX=0: hz = any valid source equal to a valid EX.rd or MEM.rd.
  - With FORWARD_EX=1: hz = any valid source equal to EX.rd with EX.v and EX.load.
  - The WB stage is never checked; the register file writes before it reads.
- States: RUN, DRAIN, HALTED.
  - pipe_en = !mem_wait && state!=HALTED.
  - RUN: stall = pipe_en && hz; ifid_en = pipe_en && !hz.
  - RUN -> DRAIN when pipe_en && !hz && id_halt (HALT accepted into EX); drain counter <= DRAIN_CYCLES.
  - DRAIN: stall = pipe_en (bubbles only); ifid_en=0; counter decrements on pipe_en cycles.
  - DRAIN -> HALTED when counter==1 and pipe_en.
  - HALTED: halted=1, stall=0, ifid_en=0, pipe_en=0. HALTED exits only via reset.
- mem_wait has priority over everything:
  - pipe_en=0, stall=0, ifid_en=0.
  - Tracking entries, drain counter and state all hold.
  - A hazard present during mem_wait resolves after the wait ends.
- A HALT that is itself hazarded stalls like any other instruction and is accepted only once hz=0.
- stall_cycles increments by 1 on each cycle with stall=1 and saturates at all-ones; it is never cleared except by reset.
- Latency: hz to stall/ifid_en is combinational (same cycle); tracking entries and state update on the next rising edge.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately; it does not wait for a clock edge.

Decomposition:
- Shared pipeline package:
  - state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
  - NOP_INSTR constant 16'h0800
  - REG_BITS default
- One natural sub-module, hz_track_entry: a single {v, rd, load} entry with enable and async active-low reset, instantiated for EX and MEM.
- The FSM and counter stay in the top level.

Test Plan:
- Reset: drive rst=0 mid-cycle -> outputs immediately stall=0, ifid_en=1, pipe_en=1, halted=0, stall_cycles=0.
- FORWARD_EX=0 RAW:
  - Issue wr r3, then decode reads rs=r3 -> stall=1, ifid_en=0 for 2 cycles (EX, then MEM match).
  - Third cycle stall=0; stall_cycles=2.
- FORWARD_EX=1 load-use:
  - Load to r5, then decode reads rt=r5 -> exactly 1 stall cycle.
  - Non-load write to r5 followed by a read of r5 -> 0 stalls.
- mem_wait during hazard:
  - Hazard present, mem_wait=1 for 4 cycles -> pipe_en=0, stall=0, entries held.
  - After the wait, the remaining stall cycles are still inserted.
- HALT drain (DRAIN_CYCLES=3):
  - HALT accepted -> 3 bubble cycles with ifid_en=0, then halted=1 and pipe_en=0, held for 10 further cycles.
  - mem_wait=1 inserted for 2 cycles in DRAIN extends the drain to 5 cycles.
- Counter saturation (CNT_W=4): force 20 consecutive hazard cycles -> stall_cycles sticks at 4'hF.
